// File: rtl/alu_exec_stage.sv
// Registered execute stage behind the ALU opcode decoder: single-cycle add/sub/and/or,
// iterative 1-bit-per-cycle sll/sra, results and flags behind a valid/ready handshake.
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       op_sel,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [SHW-1:0]   ctrl_shiftamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             isNotEqual,
  output logic             isLessThan,
  output logic             overflow,
  output logic             op_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [SHW-1:0]   SH_ONE = {{(SHW-1){1'b0}}, 1'b1};
  localparam logic [SHW-1:0]   SH_ZERO = {SHW{1'b0}};
  localparam logic [WIDTH-1:0] W_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] W_ZERO = {WIDTH{1'b0}};

  // One-bit shift step: arithmetic right replicates the MSB, otherwise logical left.
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v, input logic arith);
    if (arith) begin
      return {v[WIDTH-1], v[WIDTH-1:1]};
    end else begin
      return {v[WIDTH-2:0], 1'b0};
    end
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             sra_q, sra_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ne_q, ne_d;
  logic             lt_q, lt_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic             add_ovf_s;
  logic             sub_ovf_s;
  logic [WIDTH-1:0] shift_src_s;
  logic             shift_arith_s;
  logic [WIDTH-1:0] shifted_s;
  logic             accept_s;

  assign accept_s = in_valid && (state_q == S_IDLE);

  // Adder/subtractor datapath and signed-overflow detection.
  always_comb begin
    sum_s     = data_operandA + data_operandB;
    diff_s    = data_operandA + ~data_operandB + W_ONE;
    add_ovf_s = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1]) &&
                (sum_s[WIDTH-1] != data_operandA[WIDTH-1]);
    // Subtraction flips B's effective sign, so overflow needs differing operand signs.
    sub_ovf_s = (data_operandA[WIDTH-1] != data_operandB[WIDTH-1]) &&
                (diff_s[WIDTH-1] != data_operandA[WIDTH-1]);
  end

  // The first shift step happens at accept so an N-bit shift is visible N cycles later.
  always_comb begin
    if (state_q == S_IDLE) begin
      shift_src_s   = data_operandA;
      shift_arith_s = op_sel[5];
    end else begin
      shift_src_s   = sreg_q;
      shift_arith_s = sra_q;
    end
    shifted_s = shift1(shift_src_s, shift_arith_s);
  end

  // Next-state and datapath register update logic.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    sra_d    = sra_q;
    result_d = result_q;
    ne_d     = ne_q;
    lt_d     = lt_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          ne_d    = 1'b0;
          lt_d    = 1'b0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_HOLD;
          case (op_sel)
            6'b000001: begin
              result_d = sum_s;
              ovf_d    = add_ovf_s;
            end
            6'b000010: begin
              result_d = diff_s;
              ovf_d    = sub_ovf_s;
              lt_d     = diff_s[WIDTH-1] ^ sub_ovf_s;
              ne_d     = |(data_operandA ^ data_operandB);
            end
            6'b000100: result_d = data_operandA & data_operandB;
            6'b001000: result_d = data_operandA | data_operandB;
            6'b010000, 6'b100000: begin
              if (ctrl_shiftamt == SH_ZERO) begin
                result_d = data_operandA;
              end else if (ctrl_shiftamt == SH_ONE) begin
                result_d = shifted_s;
              end else begin
                sreg_d  = shifted_s;
                cnt_d   = ctrl_shiftamt - SH_ONE;
                sra_d   = op_sel[5];
                state_d = S_SHIFT;
              end
            end
            default: begin
              result_d = W_ZERO;
              err_d    = 1'b1;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        sreg_d = shifted_s;
        cnt_d  = cnt_q - SH_ONE;
        if (cnt_q == SH_ONE) begin
          result_d = shifted_s;
          state_d  = S_HOLD;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
    valid_d = (state_d == S_HOLD);
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sreg_q   <= W_ZERO;
      cnt_q    <= SH_ZERO;
      sra_q    <= 1'b0;
      result_q <= W_ZERO;
      ne_q     <= 1'b0;
      lt_q     <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      sra_q    <= sra_d;
      result_q <= result_d;
      ne_q     <= ne_d;
      lt_q     <= lt_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = valid_q;
  assign data_result = result_q;
  assign isNotEqual  = ne_q;
  assign isLessThan  = lt_q;
  assign overflow    = ovf_q;
  assign op_err      = err_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized self-checking bench for alu_exec_stage against an arithmetic reference model.
module tb_alu_exec_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  op_sel = 6'd0;
  logic [31:0] data_operandA = 32'd0;
  logic [31:0] data_operandB = 32'd0;
  logic [4:0]  ctrl_shiftamt = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] data_result;
  logic        isNotEqual;
  logic        isLessThan;
  logic        overflow;
  logic        op_err;

  int n_vec = 0;
  int n_err = 0;

  alu_exec_stage #(.WIDTH(32), .SHW(5)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_shiftamt(ctrl_shiftamt), .out_valid(out_valid), .out_ready(out_ready),
    .data_result(data_result), .isNotEqual(isNotEqual), .isLessThan(isLessThan),
    .overflow(overflow), .op_err(op_err)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] amt, output logic [31:0] r, output logic ne,
                       output logic lt, output logic ov, output logic er, output int lat);
    longint sa, sb, s;
    logic signed [31:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'd0; ne = 1'b0; lt = 1'b0; ov = 1'b0; er = 1'b0; lat = 1;
    if ($countones(op) != 1) begin
      er = 1'b1;
    end else if (op[0]) begin
      s  = sa + sb;
      r  = s[31:0];
      ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else if (op[1]) begin
      s  = sa - sb;
      r  = s[31:0];
      ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      lt = (sa < sb);
      ne = (a != b);
    end else if (op[2]) begin
      r = a & b;
    end else if (op[3]) begin
      r = a | b;
    end else begin
      t = a;
      r = op[4] ? (a << amt) : 32'(t >>> amt);
      lat = (amt == 5'd0) ? 1 : int'(amt);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] r, input logic ne,
                               input logic lt, input logic ov, input logic er);
    check_eq({tag, ".result"}, {32'd0, data_result}, {32'd0, r});
    check_eq({tag, ".ne"}, {63'd0, isNotEqual}, {63'd0, ne});
    check_eq({tag, ".lt"}, {63'd0, isLessThan}, {63'd0, lt});
    check_eq({tag, ".ovf"}, {63'd0, overflow}, {63'd0, ov});
    check_eq({tag, ".err"}, {63'd0, op_err}, {63'd0, er});
  endtask

  // Issue one op, measure latency, hold the result for hold_cyc cycles, then release it.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] amt, input int hold_cyc);
    logic [31:0] r;
    logic ne, lt, ov, er;
    int exp_lat, lat;
    model(op, a, b, amt, r, ne, lt, ov, er, exp_lat);
    check_eq({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; op_sel = op; data_operandA = a; data_operandB = b; ctrl_shiftamt = amt;
    @(posedge clock); #1;
    in_valid = 1'b0;
    op_sel = 6'($urandom); data_operandA = $urandom; data_operandB = $urandom;
    ctrl_shiftamt = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (in_ready) check_eq({tag, ".busy_ready"}, {63'd0, in_ready}, 64'd0);
      @(posedge clock); #1;
      lat++;
    end
    check_eq({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check_outputs(tag, r, ne, lt, ov, er);
    for (int i = 0; i < hold_cyc; i++) begin
      @(posedge clock); #1;
      check_eq({tag, ".hold_valid"}, {63'd0, out_valid}, 64'd1);
      check_eq({tag, ".hold_ready"}, {63'd0, in_ready}, 64'd0);
      check_outputs({tag, ".hold"}, r, ne, lt, ov, er);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check_eq({tag, ".drop_valid"}, {63'd0, out_valid}, 64'd0);
    check_eq({tag, ".ready_back"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [5:0] op;
    #1;
    check_eq("rst.in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst.out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst.result", {32'd0, data_result}, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    run_op("add_ovf", 6'b000001, 32'h7FFFFFFF, 32'h00000001, 5'd0, 0);
    run_op("sub_neg", 6'b000010, 32'd3, 32'd5, 5'd0, 0);
    run_op("sub_ovf", 6'b000010, 32'h80000000, 32'd1, 5'd0, 0);
    run_op("sub_eq", 6'b000010, 32'h1234, 32'h1234, 5'd0, 0);
    run_op("sra4", 6'b100000, 32'h80000000, 32'd0, 5'd4, 0);
    run_op("sll31", 6'b010000, 32'd1, 32'd0, 5'd31, 0);
    run_op("sll0", 6'b010000, 32'h12345678, 32'd0, 5'd0, 0);
    run_op("sra1", 6'b100000, 32'h80000001, 32'd0, 5'd1, 0);
    run_op("bad_op", 6'b000011, 32'hDEADBEEF, 32'h1, 5'd3, 3);
    run_op("zero_op", 6'b000000, 32'h1, 32'h1, 5'd0, 1);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = 6'd1 << $urandom_range(0, 5);
      run_op("rand", op, $urandom, $urandom, 5'($urandom), int'($urandom_range(0, 2)));
    end
    run_op("pre_rst", 6'b001000, 32'hA5A50000, 32'h00005A5A, 5'd0, 0);

    in_valid = 1'b1; op_sel = 6'b100000; data_operandA = 32'h80000000; ctrl_shiftamt = 5'd10;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    check_eq("arst.in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("arst.out_valid", {63'd0, out_valid}, 64'd0);
    check_outputs("arst", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    run_op("and_after_rst", 6'b000100, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
